// File: rtl/envase_pkg.sv
// Shared types and default parameters for the bottle fill/seal station controller.
package envase_pkg;

  // Station states; the numeric codes are visible on the estado output.
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    TRANSPORTE = 3'd1,
    ENCHIMENTO = 3'd2,
    VEDACAO    = 3'd3,
    REPOSICAO  = 3'd4,
    SAIDA      = 3'd5,
    DONE       = 3'd6,
    ALARME     = 3'd7
  } estado_t;

  localparam int LOTE_DEF       = 6;
  localparam int ROLHAS_MAX_DEF = 4;
  localparam int T_ENCHE_DEF    = 16;
  localparam int T_VEDA_DEF     = 8;

endpackage

// File: rtl/sequenciador_envase_temporizador.sv
// Clearable, enabled up-counter with a terminal-count flag against a runtime limit.
module temporizador #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limite,
  output logic         tc
);

  logic [W-1:0] contagem;

  // Clear has priority over counting so a state change always restarts at zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      contagem <= '0;
    else if (clr)
      contagem <= '0;
    else if (en)
      contagem <= contagem + 1'b1;
  end

  // Terminal count only matters while the timer is actually running.
  assign tc = en && (contagem == limite);

endmodule

// File: rtl/sequenciador_envase.sv
// Supervisory FSM for the fill/seal station: sequences conveyor, valve and sealer,
// tracks stopper stock with a refill handshake and counts bottles per batch.
module sequenciador_envase
  import envase_pkg::*;
#(
  parameter int LOTE       = LOTE_DEF,
  parameter int ROLHAS_MAX = ROLHAS_MAX_DEF,
  parameter int T_ENCHE    = T_ENCHE_DEF,
  parameter int T_VEDA     = T_VEDA_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       sensor_garrafa,
  input  logic       sensor_cheio,
  input  logic       vedacao_ok,
  input  logic       rolha_ack,
  output logic       motor,
  output logic       valvula,
  output logic       vedar,
  output logic       rolha_req,
  output logic       lote_done,
  output logic       alarme,
  output logic [2:0] estado,
  output logic [7:0] garrafas,
  output logic [7:0] rolhas
);

  localparam int T_MAX = (T_ENCHE > T_VEDA) ? T_ENCHE : T_VEDA;
  localparam int TW    = $clog2(T_MAX + 1);

  estado_t        st, st_nxt;
  logic           vedar_nxt;
  logic           tmr_tc;
  logic [TW-1:0]  tmr_limite;

  // Timeout fires on the cycle the timer holds T-1, so the state lasts at most T cycles.
  assign tmr_limite = (st == VEDACAO) ? TW'(T_VEDA - 1) : TW'(T_ENCHE - 1);

  temporizador #(.W(TW)) u_tmr (
    .clk    (clk),
    .reset  (reset),
    .clr    (st_nxt != st),
    .en     ((st == ENCHIMENTO) || (st == VEDACAO)),
    .limite (tmr_limite),
    .tc     (tmr_tc)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      st <= IDLE;
    else
      st <= st_nxt;
  end

  // Next-state logic; stop overrides everything, including start in the same cycle.
  always_comb begin
    st_nxt = st;
    if (stop) begin
      st_nxt = IDLE;
    end else begin
      case (st)
        IDLE:       if (start) st_nxt = TRANSPORTE;
        TRANSPORTE: if (sensor_garrafa) st_nxt = ENCHIMENTO;
        ENCHIMENTO: begin
          if (!sensor_garrafa)   st_nxt = ALARME;
          else if (sensor_cheio) st_nxt = VEDACAO;
          else if (tmr_tc)       st_nxt = ALARME;
        end
        VEDACAO: begin
          if (rolhas == 8'd0)  st_nxt = REPOSICAO;
          else if (vedacao_ok) st_nxt = SAIDA;
          else if (tmr_tc)     st_nxt = ALARME;
        end
        REPOSICAO:  if (rolha_ack) st_nxt = VEDACAO;
        SAIDA:      if (!sensor_garrafa)
                      st_nxt = (garrafas == 8'(LOTE)) ? DONE : TRANSPORTE;
        DONE:       if (start) st_nxt = TRANSPORTE;
        ALARME:     st_nxt = ALARME;
        default:    st_nxt = IDLE;
      endcase
    end
  end

  // A seal command is due on entry to VEDACAO if stock is available (refill always restocks).
  assign vedar_nxt = (st_nxt == VEDACAO) && (st != VEDACAO) &&
                     ((st == REPOSICAO) || (rolhas != 8'd0));

  // Registered one-cycle seal pulse aligned with the first VEDACAO cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      vedar <= 1'b0;
    else
      vedar <= vedar_nxt;
  end

  // Bottle and stopper counters, updated on the transitions that consume or restock them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      garrafas <= '0;
      rolhas   <= 8'(ROLHAS_MAX);
    end else begin
      if ((st == VEDACAO) && (st_nxt == SAIDA)) begin
        garrafas <= garrafas + 8'd1;
        rolhas   <= rolhas - 8'd1;
      end
      if ((st == REPOSICAO) && (st_nxt == VEDACAO))
        rolhas <= 8'(ROLHAS_MAX);
      if ((st == DONE) && (st_nxt == TRANSPORTE))
        garrafas <= '0;
    end
  end

  assign estado    = st;
  assign motor     = (st == TRANSPORTE) || (st == SAIDA);
  assign valvula   = (st == ENCHIMENTO);
  assign rolha_req = (st == REPOSICAO);
  assign lote_done = (st == DONE);
  assign alarme    = (st == ALARME);

endmodule

// File: tb/tb_sequenciador_envase.sv
// Self-checking bench for sequenciador_envase: table-driven first cycle plus
// hand-written multi-cycle sequences, all expectations queued and popped after each edge.
module tb_sequenciador_envase;
  import envase_pkg::*;

  localparam int LOTE = 6;
  localparam int RMAX = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0, stop = 1'b0, sg = 1'b0, sc = 1'b0, vok = 1'b0, ack = 1'b0;
  logic motor, valvula, vedar, rolha_req, lote_done, alarme;
  logic [2:0] estado;
  logic [7:0] garrafas, rolhas;

  sequenciador_envase #(.LOTE(LOTE), .ROLHAS_MAX(RMAX), .T_ENCHE(16), .T_VEDA(8)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .sensor_garrafa(sg), .sensor_cheio(sc), .vedacao_ok(vok), .rolha_ack(ack),
    .motor(motor), .valvula(valvula), .vedar(vedar), .rolha_req(rolha_req),
    .lote_done(lote_done), .alarme(alarme), .estado(estado),
    .garrafas(garrafas), .rolhas(rolhas)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic start, stop, sg, sc, vok, ack; } ent_t;
  typedef struct packed {
    logic [2:0] est;
    logic mot, val, ved, req, done, alm;
    logic [7:0] gar, rol;
  } sai_t;
  typedef struct packed { ent_t e; sai_t s; } vec_t;
  typedef struct { sai_t s; string nome; } exp_t;

  exp_t fila[$];
  vec_t tab[$];
  int checks = 0;
  int erros  = 0;
  int m_gar, m_rol;

  function automatic sai_t sai(int est, bit ved, int gar, int rol);
    sai_t r;
    r.est  = 3'(est);
    r.mot  = (est == 1) || (est == 5);
    r.val  = (est == 2);
    r.ved  = ved;
    r.req  = (est == 4);
    r.done = (est == 6);
    r.alm  = (est == 7);
    r.gar  = 8'(gar);
    r.rol  = 8'(rol);
    return r;
  endfunction

  function automatic ent_t en(bit st_i, bit sp_i, bit g_i, bit c_i, bit v_i, bit a_i);
    ent_t r;
    r.start = st_i; r.stop = sp_i; r.sg = g_i; r.sc = c_i; r.vok = v_i; r.ack = a_i;
    return r;
  endfunction

  function automatic vec_t vec(ent_t e, sai_t s);
    vec_t r;
    r.e = e; r.s = s;
    return r;
  endfunction

  function automatic sai_t obs();
    sai_t r;
    r.est = estado; r.mot = motor; r.val = valvula; r.ved = vedar;
    r.req = rolha_req; r.done = lote_done; r.alm = alarme;
    r.gar = garrafas; r.rol = rolhas;
    return r;
  endfunction

  task automatic comparar(string nome, sai_t esp);
    sai_t a;
    a = obs();
    checks++;
    if (a !== esp) begin
      erros++;
      $display("FAIL %s: got est=%0d mot=%0b val=%0b ved=%0b req=%0b done=%0b alm=%0b gar=%0d rol=%0d | want est=%0d mot=%0b val=%0b ved=%0b req=%0b done=%0b alm=%0b gar=%0d rol=%0d",
               nome, a.est, a.mot, a.val, a.ved, a.req, a.done, a.alm, a.gar, a.rol,
               esp.est, esp.mot, esp.val, esp.ved, esp.req, esp.done, esp.alm, esp.gar, esp.rol);
    end
  endtask

  // Drive inputs away from the active edge, queue the expectation, check after the edge.
  task automatic passo(ent_t e, sai_t esp, string nome);
    exp_t x;
    @(negedge clk);
    {start, stop, sg, sc, vok, ack} = e;
    x.s = esp; x.nome = nome;
    fila.push_back(x);
    @(posedge clk);
    #1;
    x = fila.pop_front();
    comparar(x.nome, x.s);
  endtask

  // One bottle from TRANSPORTE through SAIDA, including a refill when stock is empty.
  task automatic garrafa(string tag);
    passo(en(0,0,1,0,0,0), sai(2,0,m_gar,m_rol), {tag, "_enche"});
    if (m_rol == 0) begin
      passo(en(0,0,1,1,0,0), sai(3,0,m_gar,m_rol), {tag, "_veda_sem_rolha"});
      passo(en(0,0,1,0,0,0), sai(4,0,m_gar,m_rol), {tag, "_repos"});
      passo(en(0,0,1,0,1,0), sai(4,0,m_gar,m_rol), {tag, "_vok_ignorado"});
      m_rol = RMAX;
      passo(en(0,0,1,0,0,1), sai(3,1,m_gar,m_rol), {tag, "_ack_vedar"});
    end else begin
      passo(en(0,0,1,1,0,0), sai(3,1,m_gar,m_rol), {tag, "_vedar"});
    end
    m_gar++; m_rol--;
    passo(en(0,0,1,0,1,0), sai(5,0,m_gar,m_rol), {tag, "_saida"});
    passo(en(0,0,0,0,0,0), sai((m_gar == LOTE) ? 6 : 1, 0, m_gar, m_rol), {tag, "_fim"});
  endtask

  initial begin
    // First bottle cycle as a table.
    tab.push_back(vec(en(1,0,0,0,0,0), sai(1,0,0,4)));
    tab.push_back(vec(en(0,0,1,0,0,0), sai(2,0,0,4)));
    for (int i = 0; i < 4; i++) tab.push_back(vec(en(0,0,1,0,0,0), sai(2,0,0,4)));
    tab.push_back(vec(en(0,0,1,1,0,0), sai(3,1,0,4)));
    for (int i = 0; i < 2; i++) tab.push_back(vec(en(0,0,1,0,0,0), sai(3,0,0,4)));
    tab.push_back(vec(en(0,0,1,0,1,0), sai(5,0,1,3)));
    tab.push_back(vec(en(0,0,0,0,0,0), sai(1,0,1,3)));

    #1 reset = 1'b0;
    #2 comparar("reset", sai(0,0,0,RMAX));
    @(negedge clk) reset = 1'b1;

    for (int i = 0; i < tab.size(); i++)
      passo(tab[i].e, tab[i].s, $sformatf("t1[%0d]", i));
    m_gar = 1; m_rol = 3;

    // Bottles 2..6, bottle 5 runs out of stoppers and refills.
    for (int b = 2; b <= LOTE; b++) garrafa($sformatf("g%0d", b));
    passo(en(0,0,0,0,0,0), sai(6,0,m_gar,m_rol), "done_mantem");
    m_gar = 0;
    passo(en(1,0,0,0,0,0), sai(1,0,m_gar,m_rol), "done_start_zera");

    // Fill timeout: valve open for exactly 16 cycles.
    passo(en(0,0,1,0,0,0), sai(2,0,m_gar,m_rol), "to_enche_ent");
    for (int i = 0; i < 15; i++)
      passo(en(0,0,1,0,0,0), sai(2,0,m_gar,m_rol), $sformatf("to_enche[%0d]", i));
    passo(en(0,0,1,0,0,0), sai(7,0,m_gar,m_rol), "to_enche_alarme");
    passo(en(1,0,0,0,0,0), sai(7,0,m_gar,m_rol), "alarme_start_ignorado");
    passo(en(0,1,0,0,0,0), sai(0,0,m_gar,m_rol), "alarme_stop");

    // Seal timeout: VEDACAO lasts exactly 8 cycles.
    passo(en(1,0,0,0,0,0), sai(1,0,m_gar,m_rol), "tv_start");
    passo(en(0,0,1,0,0,0), sai(2,0,m_gar,m_rol), "tv_enche");
    passo(en(0,0,1,1,0,0), sai(3,1,m_gar,m_rol), "tv_vedar");
    for (int i = 0; i < 7; i++)
      passo(en(0,0,1,0,0,0), sai(3,0,m_gar,m_rol), $sformatf("tv[%0d]", i));
    passo(en(0,0,1,0,0,0), sai(7,0,m_gar,m_rol), "tv_alarme");
    passo(en(0,1,0,0,0,0), sai(0,0,m_gar,m_rol), "tv_stop");

    // Stop beats start; counters hold; start resumes the batch.
    passo(en(1,0,0,0,1,1), sai(1,0,m_gar,m_rol), "start_ack_ignorado");
    garrafa("g_r");
    passo(en(1,1,0,0,0,0), sai(0,0,m_gar,m_rol), "stop_start_juntos");
    passo(en(1,0,0,0,0,0), sai(1,0,m_gar,m_rol), "retoma_lote");

    // Bottle lost during fill.
    passo(en(0,0,1,0,0,0), sai(2,0,m_gar,m_rol), "perda_enche");
    passo(en(0,0,0,1,0,0), sai(7,0,m_gar,m_rol), "perda_alarme");
    passo(en(0,1,0,0,0,0), sai(0,0,m_gar,m_rol), "perda_stop");

    // Fresh reset, drain stock, then reset asynchronously while in REPOSICAO.
    @(negedge clk);
    {start, stop, sg, sc, vok, ack} = '0;
    reset = 1'b0;
    #1 comparar("reset2", sai(0,0,0,RMAX));
    @(negedge clk) reset = 1'b1;
    m_gar = 0; m_rol = RMAX;
    passo(en(1,0,0,0,0,0), sai(1,0,m_gar,m_rol), "r_start");
    for (int b = 1; b <= 4; b++) garrafa($sformatf("r%0d", b));
    passo(en(0,0,1,0,0,0), sai(2,0,m_gar,m_rol), "r5_enche");
    passo(en(0,0,1,1,0,0), sai(3,0,m_gar,m_rol), "r5_sem_rolha");
    passo(en(0,0,1,0,0,0), sai(4,0,m_gar,m_rol), "r5_repos");
    #2 reset = 1'b0;
    #1 comparar("reset_em_repos", sai(0,0,0,RMAX));
    {start, stop, sg, sc, vok, ack} = '0;
    @(negedge clk) reset = 1'b1;

    checks++;
    if (fila.size() != 0) begin
      erros++;
      $display("FAIL fila_vazia: got %0d pending want 0", fila.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, erros);
    $finish;
  end

endmodule
